srf04_range_ctrl: RTL and testbench

//  Sequences one SRF04 ranging cycle: trigger pulse, echo-width timing, conversion to integer cm,

---
 rtl/srf04_range_ctrl.sv | 178 +++++++++++++++++
 tb/tb_srf04_range_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/srf04_range_ctrl.sv
// SRF04 ranging sequencer: trigger, echo timing, cm conversion,
// hand-off to an external binary-to-BCD converter and digit latching.
module srf04_range_ctrl #(
    parameter int TRIG_CYC   = 500,
    parameter int CYC_PER_CM = 2900,
    parameter int MAX_CM     = 400,
    parameter int ECHO_WAIT  = 1500000,
    parameter int COOL_CYC   = 500000,
    parameter int TMR_W      = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       echo,
    output logic       trig,
    output logic [9:0] dist_bin,
    input  logic [3:0] bcd_ones,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_hund,
    input  logic [3:0] bcd_thou,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       valid,
    output logic       oor,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        LOAD,
        CONVERT,
        COOL
    } state_e;

    localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYC - 1);
    localparam logic [TMR_W-1:0] CPC_LAST  = TMR_W'(CYC_PER_CM - 1);
    localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(ECHO_WAIT - 1);
    localparam logic [TMR_W-1:0] COOL_LAST = TMR_W'(COOL_CYC - 1);
    localparam logic [9:0]       CM_MAX    = 10'(MAX_CM);

    state_e           state_q;
    logic [TMR_W-1:0] timer_q;
    logic [9:0]       cm_q;
    logic             oor_next_q;
    logic             echo_meta_q;
    logic             echo_s_q;
    logic             trig_q;
    logic             busy_q;
    logic             valid_q;
    logic             oor_q;
    logic [9:0]       dist_q;
    logic [3:0]       dig0_q;
    logic [3:0]       dig1_q;
    logic [3:0]       dig2_q;
    logic [3:0]       dig3_q;

    logic             wrap_d;
    logic [9:0]       cm_d;
    logic             sat_d;

    assign wrap_d = (timer_q == CPC_LAST);
    assign cm_d   = wrap_d ? cm_q + 10'd1 : cm_q;
    assign sat_d  = wrap_d && (cm_d == CM_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
        end else begin
            echo_meta_q <= echo;
            echo_s_q    <= echo_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            cm_q       <= '0;
            oor_next_q <= 1'b0;
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            oor_q      <= 1'b0;
            dist_q     <= '0;
            dig0_q     <= '0;
            dig1_q     <= '0;
            dig2_q     <= '0;
            dig3_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // a stuck-high echo means the sensor is still busy
                    if (en && !echo_s_q) begin
                        state_q <= TRIG;
                        trig_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        timer_q <= '0;
                    end
                end
                TRIG: begin
                    if (timer_q == TRIG_LAST) begin
                        state_q <= WAIT_RISE;
                        trig_q  <= 1'b0;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                WAIT_RISE: begin
                    if (echo_s_q) begin
                        state_q <= MEASURE;
                        timer_q <= '0;
                        cm_q    <= '0;
                    end else if (timer_q == WAIT_LAST) begin
                        state_q    <= LOAD;
                        cm_q       <= CM_MAX;
                        oor_next_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                MEASURE: begin
                    timer_q <= wrap_d ? '0 : timer_q + 1'b1;
                    cm_q    <= cm_d;
                    // saturation outranks a coincident echo fall
                    if (sat_d) begin
                        state_q    <= LOAD;
                        oor_next_q <= 1'b1;
                    end else if (!echo_s_q) begin
                        state_q    <= LOAD;
                        oor_next_q <= 1'b0;
                    end
                end
                LOAD: begin
                    dist_q  <= cm_q;
                    state_q <= CONVERT;
                end
                CONVERT: begin
                    dig0_q  <= bcd_ones;
                    dig1_q  <= bcd_tens;
                    dig2_q  <= bcd_hund;
                    dig3_q  <= bcd_thou;
                    oor_q   <= oor_next_q;
                    valid_q <= 1'b1;
                    timer_q <= '0;
                    state_q <= COOL;
                end
                COOL: begin
                    if (timer_q == COOL_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign trig     = trig_q;
    assign busy     = busy_q;
    assign valid    = valid_q;
    assign oor      = oor_q;
    assign dist_bin = dist_q;
    assign dig0     = dig0_q;
    assign dig1     = dig1_q;
    assign dig2     = dig2_q;
    assign dig3     = dig3_q;

endmodule

// File: tb/tb_srf04_range_ctrl.sv
// Directed bench for srf04_range_ctrl with a behavioural BCD converter
// and a result scoreboard checked on every valid pulse.
module tb_srf04_range_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       echo = 1'b0;
    logic       trig;
    logic [9:0] dist_bin;
    logic [3:0] bcd_ones, bcd_tens, bcd_hund, bcd_thou;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic       valid, oor, busy;

    typedef struct {
        logic [9:0]  d;
        logic [15:0] g;
        logic        o;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   vcnt = 0;
    int   pushes = 0;
    logic prev_v = 1'b0;

    srf04_range_ctrl #(
        .TRIG_CYC(3), .CYC_PER_CM(4), .MAX_CM(400),
        .ECHO_WAIT(50), .COOL_CYC(8), .TMR_W(21)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .echo(echo), .trig(trig),
        .dist_bin(dist_bin), .bcd_ones(bcd_ones), .bcd_tens(bcd_tens),
        .bcd_hund(bcd_hund), .bcd_thou(bcd_thou), .dig0(dig0), .dig1(dig1),
        .dig2(dig2), .dig3(dig3), .valid(valid), .oor(oor), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        bcd_ones = 4'(dist_bin % 10);
        bcd_tens = 4'((dist_bin / 10) % 10);
        bcd_hund = 4'((dist_bin / 100) % 10);
        bcd_thou = 4'(dist_bin / 1000);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [9:0] d, input logic [15:0] g,
                        input logic o);
        res_t r;
        r.d = d;
        r.g = g;
        r.o = o;
        sb.push_back(r);
        pushes++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_trig(input logic v, input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            tick(1);
            if (trig === v) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            tick(1);
            if (valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            tick(1);
            if (busy === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    // one trigger with en dropped right after it, returning at trig fall
    task automatic fire(output int rise, output int width);
        en = 1'b1;
        wait_trig(1'b1, 10, rise);
        en = 1'b0;
        wait_trig(1'b0, 10, width);
    endtask

    always @(negedge clk) begin
        res_t r;
        if (rst_n && valid === 1'b1) begin
            vcnt++;
            chk("valid_pulse", 32'(prev_v), 0);
            chk("sb_avail", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                r = sb.pop_front();
                chk("dist_bin", 32'(dist_bin), 32'(r.d));
                chk("digits", 32'({dig3, dig2, dig1, dig0}), 32'(r.g));
                chk("oor", 32'(oor), 32'(r.o));
            end
        end
        prev_v = valid;
    end

    initial begin
        int   n, w;
        logic seen;

        #2;
        chk("rst_ctrl", 32'({trig, busy, valid, oor}), 0);
        chk("rst_dist", 32'(dist_bin), 0);
        chk("rst_dig", 32'({dig3, dig2, dig1, dig0}), 0);
        tick(2);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (trig !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        chk("idle_en0", 32'(seen), 0);

        push(10'd123, 16'h0123, 1'b0);
        fire(n, w);
        chk("trig_rise", n, 1);
        chk("trig_width", w, 3);
        chk("busy_run", 32'(busy), 1);
        echo = 1'b1;
        tick(492);
        echo = 1'b0;
        wait_valid(20, n);
        chk("echo_to_valid", n, 5);
        wait_idle(20, n);
        chk("cool_len", n, 8);

        push(10'd400, 16'h0400, 1'b1);
        fire(n, w);
        wait_valid(80, n);
        chk("timeout_lat", n, 52);
        wait_idle(20, n);

        push(10'd400, 16'h0400, 1'b1);
        fire(n, w);
        echo = 1'b1;
        wait_valid(1700, n);
        chk("sat_lat", n, 1605);
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 395; i++) begin
            tick(1);
            if (trig !== 1'b0) seen = 1'b1;
        end
        chk("no_trig_echo_hi", 32'(seen), 0);
        chk("idle_echo_hi", 32'(busy), 0);
        push(10'd400, 16'h0400, 1'b1);
        echo = 1'b0;
        wait_trig(1'b1, 10, n);
        chk("trig_after_release", n, 3);
        en = 1'b0;
        wait_trig(1'b0, 10, n);
        wait_valid(80, n);
        wait_idle(20, n);

        fire(n, w);
        echo = 1'b1;
        tick(20);
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl", 32'({trig, busy, valid, oor}), 0);
        chk("arst_dist", 32'(dist_bin), 0);
        chk("arst_dig", 32'({dig3, dig2, dig1, dig0}), 0);
        echo = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);

        push(10'd10, 16'h0010, 1'b0);
        fire(n, w);
        chk("post_rst_width", w, 3);
        echo = 1'b1;
        tick(40);
        echo = 1'b0;
        wait_valid(20, n);
        chk("post_rst_lat", n, 5);
        wait_idle(20, n);

        tick(5);
        chk("sb_empty", 32'(sb.size()), 0);
        chk("valid_count", vcnt, pushes);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
